// File: rtl/gest_pkg.sv
// Shared types for the ring gesture recogniser: bands, ring zones,
// per-hand tracker states and the band-pair to ring-index lookup.
package gest_pkg;

  typedef enum logic [1:0] {
    B_LOW,
    B_MID,
    B_HIGH
  } band_e;

  typedef logic [2:0] ring_idx_t;

  typedef struct packed {
    logic      center;
    ring_idx_t idx;
  } zone_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CCW,
    S_CW
  } gst_e;

  localparam logic [3:0] STEPS = 4'd8;

  // Border cells numbered counter-clockwise from top-middle
  function automatic zone_t ring_lookup(input band_e bx, input band_e by);
    zone_t zn;
    zn.center = 1'b0;
    zn.idx    = 3'd0;
    unique case (1'b1)
      (bx == B_MID  && by == B_HIGH): zn.idx = 3'd0;
      (bx == B_LOW  && by == B_HIGH): zn.idx = 3'd1;
      (bx == B_LOW  && by == B_MID):  zn.idx = 3'd2;
      (bx == B_LOW  && by == B_LOW):  zn.idx = 3'd3;
      (bx == B_MID  && by == B_LOW):  zn.idx = 3'd4;
      (bx == B_HIGH && by == B_LOW):  zn.idx = 3'd5;
      (bx == B_HIGH && by == B_MID):  zn.idx = 3'd6;
      (bx == B_HIGH && by == B_HIGH): zn.idx = 3'd7;
      default:                        zn.center = 1'b1;
    endcase
    return zn;
  endfunction

endpackage

// File: rtl/gest_ring_tracker.sv
// Per-hand ring walker: follows consecutive border steps, flags a full
// circle and its direction, and abandons a circle that stalls too long.
module gest_ring_tracker
  import gest_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic  clock,
  input  logic  reset_n,
  input  logic  i_valid,
  input  zone_t i_zone,
  output logic  o_done,
  output logic  o_dir
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYC);

  gst_e          r_st, w_st, w_nst;
  logic [3:0]    r_cnt, w_cnt, w_ncnt;
  ring_idx_t     r_prev, w_nprev, w_pp1, w_pm1;
  logic [TW-1:0] r_tmr;
  logic          w_fwd, w_bwd, w_same;

  assign w_pp1  = r_prev + 3'd1;
  assign w_pm1  = r_prev - 3'd1;
  assign w_fwd  = (i_zone.idx == w_pp1);
  assign w_bwd  = (i_zone.idx == w_pm1);
  assign w_same = (i_zone.idx == r_prev);

  always_comb begin
    w_st    = r_st;
    w_cnt   = r_cnt;
    o_done  = 1'b0;
    o_dir   = 1'b0;
    // A stalled circle falls back to ARMED before this sample is applied
    if ((r_st == S_CCW || r_st == S_CW) && r_tmr == TMO) begin
      w_st  = S_ARMED;
      w_cnt = 4'd0;
    end
    w_nst   = w_st;
    w_ncnt  = w_cnt;
    w_nprev = r_prev;
    if (i_valid) begin
      if (i_zone.center) begin
        w_nst  = S_IDLE;
        w_ncnt = 4'd0;
      end else begin
        unique case (w_st)
          S_IDLE: begin
            w_nst   = S_ARMED;
            w_ncnt  = 4'd0;
            w_nprev = i_zone.idx;
          end
          S_ARMED: begin
            if (w_fwd) begin
              w_nst   = S_CCW;
              w_ncnt  = 4'd1;
              w_nprev = i_zone.idx;
            end else if (w_bwd) begin
              w_nst   = S_CW;
              w_ncnt  = 4'd1;
              w_nprev = i_zone.idx;
            end else if (!w_same) begin
              w_ncnt  = 4'd0;
              w_nprev = i_zone.idx;
            end
          end
          S_CCW, S_CW: begin
            if ((w_st == S_CCW) ? w_fwd : w_bwd) begin
              w_ncnt  = w_cnt + 4'd1;
              w_nprev = i_zone.idx;
            end else if (!w_same) begin
              w_nst   = S_ARMED;
              w_ncnt  = 4'd0;
              w_nprev = i_zone.idx;
            end
          end
        endcase
        if (w_ncnt == STEPS) begin
          o_done = 1'b1;
          o_dir  = (w_st == S_CCW);
          w_nst  = S_ARMED;
          w_ncnt = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_st   <= S_IDLE;
      r_cnt  <= 4'd0;
      r_prev <= 3'd0;
      r_tmr  <= '0;
    end else begin
      r_st   <= w_nst;
      r_cnt  <= w_ncnt;
      r_prev <= w_nprev;
      if (i_valid && (i_zone.center || !w_same)) begin
        r_tmr <= '0;
      end else if (r_tmr != TMO) begin
        r_tmr <= r_tmr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/gest_rec_ring.sv
// Multi-hand ring gesture recogniser: zone classification, circle
// arbitration, arm state and saturated hover/roll/pitch commands.
module gest_rec_ring
  import gest_pkg::*;
#(
  parameter int unsigned         COORD_W     = 16,
  parameter int unsigned         NUM_HANDS   = 2,
  parameter int unsigned         CMD_W       = 8,
  parameter logic [COORD_W-1:0] ZONE_LO     = 'h5555,
  parameter logic [COORD_W-1:0] ZONE_HI     = 'hAAAA,
  parameter int unsigned         TIMEOUT_CYC = 50_000_000,
  parameter int unsigned         CMD_SHIFT   = 8,
  parameter int unsigned         DEADBAND    = 2
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           sample_valid,
  input  logic [NUM_HANDS*COORD_W-1:0]   x,
  input  logic [NUM_HANDS*COORD_W-1:0]   y,
  input  logic [NUM_HANDS*COORD_W-1:0]   z,
  output logic [CMD_W-1:0]               hover,
  output logic [CMD_W-1:0]               roll,
  output logic [CMD_W-1:0]               pitch,
  output logic                           on,
  output logic                           cmd_valid,
  output logic                           gest_pulse,
  output logic                           gest_dir
);

  localparam int unsigned DW = COORD_W + 1;
  localparam int unsigned NB = NUM_HANDS - 1;
  typedef logic signed [DW-1:0] diff_t;
  localparam diff_t SMAX = diff_t'(2 ** (CMD_W - 1) - 1);
  localparam diff_t SMIN = -SMAX - diff_t'(1);
  localparam diff_t DB   = diff_t'(DEADBAND);

  function automatic band_e band_of(input logic [COORD_W-1:0] c);
    if (c < ZONE_LO) return B_LOW;
    if (c > ZONE_HI) return B_HIGH;
    return B_MID;
  endfunction

  function automatic logic [CMD_W-1:0] sat_db(input diff_t d);
    diff_t s;
    s = d >>> CMD_SHIFT;
    if (s > SMAX) s = SMAX;
    else if (s < SMIN) s = SMIN;
    if (s < DB && s > -DB) s = '0;
    return s[CMD_W-1:0];
  endfunction

  zone_t [NUM_HANDS-1:0] w_zone, r_zone;
  diff_t                 w_dy, w_dz, r_dy, r_dz;
  logic [CMD_W-1:0]      r_hz;
  logic                  r_s1v;
  logic [NUM_HANDS-1:0]  w_done, w_dirh;
  logic                  w_win, w_dir, w_on;
  logic                  r_on, r_cv, r_gp, r_gd;
  logic [CMD_W-1:0]      r_hover, r_roll, r_pitch;

  always_comb begin
    for (int h = 0; h < NUM_HANDS; h++) begin
      w_zone[h] = ring_lookup(band_of(x[h*COORD_W +: COORD_W]),
                              band_of(y[h*COORD_W +: COORD_W]));
    end
  end

  assign w_dy = diff_t'({1'b0, y[0 +: COORD_W]})
              - diff_t'({1'b0, y[NB*COORD_W +: COORD_W]});
  assign w_dz = diff_t'({1'b0, z[0 +: COORD_W]})
              - diff_t'({1'b0, z[NB*COORD_W +: COORD_W]});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1v  <= 1'b0;
      r_zone <= '0;
      r_dy   <= '0;
      r_dz   <= '0;
      r_hz   <= '0;
    end else begin
      r_s1v <= sample_valid;
      if (sample_valid) begin
        r_zone <= w_zone;
        r_dy   <= w_dy;
        r_dz   <= w_dz;
        r_hz   <= z[COORD_W-1 -: CMD_W];
      end
    end
  end

  for (genvar h = 0; h < NUM_HANDS; h++) begin : g_trk
    gest_ring_tracker #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_trk (
      .clock  (clock),
      .reset_n(reset_n),
      .i_valid(r_s1v),
      .i_zone (r_zone[h]),
      .o_done (w_done[h]),
      .o_dir  (w_dirh[h])
    );
  end

  // Descending scan so the lowest completing hand is applied last
  always_comb begin
    w_win = 1'b0;
    w_dir = 1'b0;
    for (int h = NUM_HANDS - 1; h >= 0; h--) begin
      if (w_done[h]) begin
        w_win = 1'b1;
        w_dir = w_dirh[h];
      end
    end
  end

  assign w_on = w_win ? w_dir : r_on;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_on    <= 1'b0;
      r_cv    <= 1'b0;
      r_gp    <= 1'b0;
      r_gd    <= 1'b0;
      r_hover <= '0;
      r_roll  <= '0;
      r_pitch <= '0;
    end else begin
      r_cv <= r_s1v;
      r_gp <= w_win;
      r_gd <= w_win & w_dir;
      if (r_s1v) begin
        r_on    <= w_on;
        r_hover <= w_on ? r_hz : '0;
        r_roll  <= w_on ? sat_db(r_dy) : '0;
        r_pitch <= w_on ? sat_db(r_dz) : '0;
      end
    end
  end

  assign on         = r_on;
  assign cmd_valid  = r_cv;
  assign gest_pulse = r_gp;
  assign gest_dir   = r_gd;
  assign hover      = r_hover;
  assign roll       = r_roll;
  assign pitch      = r_pitch;

endmodule

// File: doc/gest_rec_ring.md
# gest_rec_ring

Parametrised successor to the two-hand gesture recogniser: classifies each of NUM_HANDS tracked hand positions into a 3x3 zone grid and detects full circular gestures around the border ring. A counter-clockwise circle on any hand arms the drone; a clockwise circle disarms it. While armed, it derives hover/roll/pitch commands from hand 0 and hand NUM_HANDS-1, with saturation and deadband. It sits between the position tracker and the drone command encoder.

## Interface
- COORD_W, 16: unsigned coordinate width.
- NUM_HANDS, 2: tracked channels, ≥2.
- CMD_W, 8: command output width.
- ZONE_LO, 16'h5555: coord < ZONE_LO is band LOW.
- ZONE_HI, 16'hAAAA: coord > ZONE_HI is band HIGH; otherwise band MID.
- TIMEOUT_CYC, 50_000_000: maximum clocks between ring steps.
- CMD_SHIFT, 8: arithmetic right shift applied to roll and pitch differences.
- DEADBAND, 2: |roll| or |pitch| < DEADBAND outputs 0.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_valid  in  1  x/y/z hold a new sample this cycle.
- x, y, z  in  NUM_HANDS*COORD_W each  packed coordinates; hand i occupies [i*COORD_W +: COORD_W].
- hover  out  CMD_W  unsigned altitude command.
- roll, pitch  out  CMD_W  two's-complement commands.
- on  out  1  armed flag.
- cmd_valid  out  1  one-cycle strobe; hover/roll/pitch/on updated.
- gest_pulse  out  1  one-cycle strobe; circle completed.
- gest_dir  out  1  1 = CCW, 0 = CW; valid with gest_pulse.

## Operation
- Zone: (x band, y band). Ring index: 0 = (MID,HIGH), 1 = (LOW,HIGH), 2 = (LOW,MID), 3 = (LOW,LOW), 4 = (MID,LOW), 5 = (HIGH,LOW), 6 = (HIGH,MID), 7 = (HIGH,HIGH). (MID,MID) = CENTER.
- Per-hand FSM, updated only on accepted samples: IDLE, ARMED, CCW, CW; step count 0..8.
  - IDLE: ring zone → ARMED, count 0, prev = idx. CENTER → stay.
  - ARMED: idx = prev+1 mod 8 → CCW, count 1. idx = prev−1 mod 8 → CW, count 1. Same idx → hold. CENTER → IDLE. Any other idx → ARMED, count 0, prev = idx.
  - CCW/CW: step in the same direction → count+1. Same idx → hold. Reverse step or skip → ARMED at the new idx, count 0. CENTER → IDLE.
  - Count reaching 8 → channel completion, FSM → ARMED at current idx, count 0.
- Timeout: per-hand counter clears on every idx change and saturates at TIMEOUT_CYC. Reaching TIMEOUT_CYC in CCW/CW forces ARMED, count 0, at the current prev.
- Completions: several hands completing on the same sample → lowest hand index wins. gest_pulse=1, gest_dir as above. CCW sets on=1; CW clears on. A completion that does not change on still pulses.
- Commands while on=1, using hands 0 (a) and N = NUM_HANDS-1 (b):
  - hover = z_a[COORD_W-1 -: CMD_W].
  - roll = sat((y_a − y_b) >>> CMD_SHIFT).
  - pitch = sat((z_a − z_b) >>> CMD_SHIFT).
  - Differences computed at COORD_W+1 bits signed. sat clamps to [−2^(CMD_W−1), 2^(CMD_W−1)−1], then the deadband applies.
- While on=0, hover/roll/pitch = 0.

## Timing
- Reset: all outputs 0, every FSM IDLE, counts and timeouts 0.
- Pipeline: stage 1 registers zone indices and differences; stage 2 updates FSMs, on, commands. cmd_valid, gest_pulse, on, and commands appear 2 cycles after sample_valid.
- on changes in the same cycle as gest_pulse. Commands in that cycle already reflect the new on.
- Back-to-back samples every cycle are sustained. No backpressure.
- reset_n asserted mid-circle aborts all progress. In-flight stage-1 data is discarded.

## Structure
- Package gest_pkg holds:
  - band enum LOW/MID/HIGH
  - ring index type (3 bits) plus CENTER flag
  - FSM state enum IDLE/ARMED/CCW/CW
  - the ring-index lookup function
- Sub-module gest_ring_tracker: one per hand (generate loop). Contains the FSM, step count, and timeout counter. Outputs done and dir.
- Top level holds classification, arbitration, on register, and command arithmetic.

## Test plan
All scenarios except 3 override ZONE_LO=3, ZONE_HI=6.
1. Reset: hold reset_n=0 for 5 cycles with random inputs → all outputs 0. After release, no cmd_valid until sample_valid.
2. CCW circle: hand 0 (x,y) = (5,7), (2,7), (2,5), (2,2), (5,2), (7,2), (7,5), (7,7), (5,7), one per cycle. → gest_pulse=1, gest_dir=1, on=1 exactly 2 cycles after the 9th sample. No earlier pulse.
3. Commands (default zones, on=1):
   - y0=16'h9000, y1=16'h8000, z0=16'hF000, z1=16'h1000 → hover=8'hF0, roll=16, pitch=127.
   - y0−y1 = 16'h0100 → roll=1 → 0 (deadband).
4. Skip: (5,7) → (2,5) jump mid-sequence, then continue → no pulse until 8 further consecutive CCW steps. Reversal after 4 steps likewise restarts.
5. Timeout: TIMEOUT_CYC=20. Pause 20 cycles at (2,2) mid-circle, then finish → no pulse. Pause of 19 cycles → pulse.
6. Disarm/arbitration:
   - On the same sample, hand 0 completes CW and hand 1 completes CCW → gest_dir=0, on=0, commands 0.
   - reset_n pulse at step 5 → later CCW needs a full 8 steps.
